// File: rtl/bcd_time_loader_if.sv
// Digit-entry / time-output bundle shared by the loader and whatever feeds it.
// The master drives digits and abort; the slave (the loader) returns status and time.
interface bcd_time_loader_if;
    logic       digit_valid;
    logic [3:0] digit;
    logic       abort;
    logic       busy;
    logic [2:0] digit_idx;
    logic       load;
    logic       err;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [6:0] m_seconds;

    modport master (
        output digit_valid, digit, abort,
        input  busy, digit_idx, load, err, minutes, seconds, m_seconds
    );

    modport slave (
        input  digit_valid, digit, abort,
        output busy, digit_idx, load, err, minutes, seconds, m_seconds
    );
endinterface

// File: rtl/bcd_time_loader.sv
// Collects six display-code digits (mm ss hh), converts each pair to binary over
// three cycles, then either loads the time outputs or flags the entry as invalid.
module bcd_time_loader (
    input  logic                mili_clk,
    input  logic                reset,
    bcd_time_loader_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_CONVERT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [3:0] r_digits [6];
    logic [2:0] r_digit_idx;
    logic [1:0] r_conv_cnt;
    logic       r_err_pending;
    logic [6:0] r_min_f;
    logic [6:0] r_sec_f;
    logic [5:0] r_minutes;
    logic [5:0] r_seconds;
    logic [6:0] r_m_seconds;

    logic       w_accepting;
    logic       w_take;
    logic       w_illegal;
    logic       w_legal_take;
    logic       w_time_ok;
    logic [3:0] w_tens;
    logic [3:0] w_ones;
    logic [6:0] w_field;

    // Blank (code 10) contributes the value 0 to its field.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_val
            logic [3:0] w_val;
            assign w_val = (r_digits[gi] == 4'd10) ? 4'd0 : r_digits[gi];
        end
    endgenerate

    assign w_accepting  = (r_state == S_IDLE) || (r_state == S_COLLECT);
    assign w_take       = w_accepting && bus.digit_valid && !bus.abort;
    assign w_illegal    = (bus.digit > 4'd10);
    assign w_legal_take = w_take && !w_illegal;
    assign w_time_ok    = (g_val[0].w_val <= 4'd5) && (g_val[2].w_val <= 4'd5);

    always_comb begin
        w_tens = g_val[4].w_val;
        w_ones = g_val[5].w_val;
        case (r_conv_cnt)
            2'd0: begin
                w_tens = g_val[0].w_val;
                w_ones = g_val[1].w_val;
            end
            2'd1: begin
                w_tens = g_val[2].w_val;
                w_ones = g_val[3].w_val;
            end
            default: ;
        endcase
        w_field = ({3'b000, w_tens} << 3) + ({3'b000, w_tens} << 1) + {3'b000, w_ones};
    end

    always_ff @(posedge mili_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_COLLECT: begin
                if (bus.abort) begin
                    w_state_next = S_IDLE;
                end else if (bus.digit_valid) begin
                    if (w_illegal) begin
                        w_state_next = S_IDLE;
                    end else if (r_digit_idx == 3'd5) begin
                        w_state_next = S_CONVERT;
                    end else begin
                        w_state_next = S_COLLECT;
                    end
                end
            end
            S_CONVERT: begin
                if (r_conv_cnt == 2'd2) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // An illegal digit reports one cycle late, from IDLE, so it can never meet DONE.
    always_comb begin
        bus.busy = 1'b0;
        bus.load = 1'b0;
        bus.err  = r_err_pending;
        case (r_state)
            S_CONVERT: bus.busy = 1'b1;
            S_DONE: begin
                bus.load = w_time_ok;
                bus.err  = !w_time_ok;
            end
            default: ;
        endcase
    end

    always_ff @(posedge mili_clk) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) begin
                r_digits[i] <= '0;
            end
            r_digit_idx   <= '0;
            r_conv_cnt    <= '0;
            r_err_pending <= 1'b0;
            r_min_f       <= '0;
            r_sec_f       <= '0;
            r_minutes     <= '0;
            r_seconds     <= '0;
            r_m_seconds   <= '0;
        end else begin
            r_err_pending <= w_take && w_illegal;

            for (int i = 0; i < 6; i++) begin
                if (w_state_next == S_IDLE) begin
                    r_digits[i] <= '0;
                end else if (w_legal_take && (r_digit_idx == 3'(i))) begin
                    r_digits[i] <= bus.digit;
                end
            end

            if (w_state_next == S_IDLE) begin
                r_digit_idx <= '0;
            end else if (w_legal_take) begin
                r_digit_idx <= r_digit_idx + 3'd1;
            end

            if (r_state == S_CONVERT) begin
                r_conv_cnt <= r_conv_cnt + 2'd1;
                case (r_conv_cnt)
                    2'd0:    r_min_f <= w_field;
                    2'd1:    r_sec_f <= w_field;
                    default: ;
                endcase
            end else begin
                r_conv_cnt <= '0;
            end

            // Last conversion edge: hundredths go straight out so load and data coincide.
            if ((r_state == S_CONVERT) && (r_conv_cnt == 2'd2) && w_time_ok) begin
                r_minutes   <= r_min_f[5:0];
                r_seconds   <= r_sec_f[5:0];
                r_m_seconds <= w_field;
            end
        end
    end

    assign bus.digit_idx = r_digit_idx;
    assign bus.minutes   = r_minutes;
    assign bus.seconds   = r_seconds;
    assign bus.m_seconds = r_m_seconds;

endmodule
